rx_ack_flow_tracker: RTL and testbench

RX_ACK_FLOW_TRACKER -- requirements
Module: rx_ack_flow_tracker

---
 rtl/tcp_pkg.sv | 39 +++
 rtl/rx_ack_calc.sv | 32 +++
 rtl/rx_ack_flow_tracker.sv | 166 ++++++++++++++++
 tb/tb_rx_ack_flow_tracker.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_pkg.sv
// Shared widths, per-flow receive-ack state record and small helpers for
// the TCP receive path. Sequence/ack numbers are 32-bit; payload ring
// pointers carry one extra wrap bit above RX_PAYLOAD_PTR_W.
package tcp_pkg;

    localparam int ACK_NUM_W           = 32;
    localparam int SEQ_NUM_W           = 32;
    localparam int RX_PAYLOAD_PTR_W    = 10;
    // Pointer width including the wrap bit (full/empty disambiguation).
    localparam int RX_PAYLOAD_IDX_W    = RX_PAYLOAD_PTR_W + 1;
    // One packet may legally cover the whole ring, so length needs the wrap bit too.
    localparam int PAYLOAD_ENTRY_LEN_W = RX_PAYLOAD_PTR_W + 1;
    localparam int DUP_CNT_W           = 3;

    localparam logic [RX_PAYLOAD_IDX_W-1:0] RX_BUF_SIZE = RX_PAYLOAD_IDX_W'(1) << RX_PAYLOAD_PTR_W;
    localparam logic [DUP_CNT_W-1:0]        DUP_CNT_MAX = '1;

    typedef struct packed {
        logic [ACK_NUM_W-1:0]        ack_num;
        logic [RX_PAYLOAD_IDX_W-1:0] tail_ptr;
        logic [RX_PAYLOAD_IDX_W-1:0] head_ptr;
    } rx_ack_state_struct;

    // Saturating duplicate-ack counter step: cleared by an accepted packet,
    // otherwise bumped until it pins at the maximum.
    function automatic logic [DUP_CNT_W-1:0] dup_cnt_step(
        input logic [DUP_CNT_W-1:0] cnt,
        input logic                 accept
    );
        if (accept) begin
            return '0;
        end
        if (cnt == DUP_CNT_MAX) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/rx_ack_calc.sv
// Purpose : accept/reject decision and next ack/tail/window for one packet.
// Latency : purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
// Ports   : state (current flow record), seq/len (packet), accept, ack_next
//           (new ack or duplicate ack), tail_next, win (advertised window).
module rx_ack_calc
    import tcp_pkg::*;
(
    input  rx_ack_state_struct               state,
    input  logic [SEQ_NUM_W-1:0]             seq,
    input  logic [PAYLOAD_ENTRY_LEN_W-1:0]   len,
    output logic                             accept,
    output logic [ACK_NUM_W-1:0]             ack_next,
    output logic [RX_PAYLOAD_IDX_W-1:0]      tail_next,
    output logic [RX_PAYLOAD_IDX_W-1:0]      win
);

    logic [RX_PAYLOAD_IDX_W-1:0] used;
    logic [RX_PAYLOAD_IDX_W-1:0] left;

    // Pointers carry a wrap bit, so the modular difference is the occupancy.
    assign used = state.tail_ptr - state.head_ptr;
    assign left = RX_BUF_SIZE - used;

    // Exact equality only: out-of-order data is not buffered, and wrap of
    // the 32-bit sequence space needs no special casing.
    assign accept    = (seq == state.ack_num) && (left >= len);
    assign ack_next  = accept ? (seq + ACK_NUM_W'(len)) : state.ack_num;
    assign tail_next = accept ? (state.tail_ptr + len) : state.tail_ptr;
    assign win       = accept ? (left - len) : left;

endmodule

// File: rtl/rx_ack_flow_tracker.sv
// Purpose : per-flow in-order receive tracker producing ack number, write
//           pointer and window for each arriving packet.
// Latency : packet transferred in cycle N -> result register valid in N+2.
// Backpressure: pkt_rdy = !S1 valid | output free; S1 holds while res stalls.
// Ports   : init_* (re)arms a flow; pkt_* valid/ready packet input; cons_*
//           application head-pointer update (always accepted); res_* result.
// Build option: define RX_ACK_DUPCNT_EN to add a per-flow saturating
//           duplicate-ack counter reported on res_dup_cnt.
module rx_ack_flow_tracker
    import tcp_pkg::*;
#(
    parameter int NUM_FLOWS = 8,
    parameter int FLOW_ID_W = $clog2(NUM_FLOWS)
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             init_val,
    input  logic [FLOW_ID_W-1:0]             init_flow_id,
    input  logic [ACK_NUM_W-1:0]             init_ack_num,

    input  logic                             pkt_val,
    output logic                             pkt_rdy,
    input  logic [FLOW_ID_W-1:0]             pkt_flow_id,
    input  logic [SEQ_NUM_W-1:0]             pkt_seq_num,
    input  logic [PAYLOAD_ENTRY_LEN_W-1:0]   pkt_payload_len,

    input  logic                             cons_val,
    input  logic [FLOW_ID_W-1:0]             cons_flow_id,
    input  logic [RX_PAYLOAD_PTR_W:0]        cons_head_ptr,

    output logic                             res_val,
    input  logic                             res_rdy,
    output logic [FLOW_ID_W-1:0]             res_flow_id,
    output logic [ACK_NUM_W-1:0]             res_ack_num,
    output logic                             res_accept,
    output logic [RX_PAYLOAD_PTR_W:0]        res_wr_ptr,
    output logic [RX_PAYLOAD_PTR_W:0]        res_win
`ifdef RX_ACK_DUPCNT_EN
    ,
    output logic [DUP_CNT_W-1:0]             res_dup_cnt
`endif
);

    rx_ack_state_struct flow_state [NUM_FLOWS];

    // Stage-1 packet register.
    logic                            s1_val;
    logic [FLOW_ID_W-1:0]            s1_flow_id;
    logic [SEQ_NUM_W-1:0]            s1_seq;
    logic [PAYLOAD_ENTRY_LEN_W-1:0]  s1_len;

    logic                            out_free;
    logic                            s1_fire;
    logic                            pkt_fire;

    rx_ack_state_struct              s1_state;
    logic                            calc_accept;
    logic [ACK_NUM_W-1:0]            calc_ack;
    logic [RX_PAYLOAD_IDX_W-1:0]     calc_tail;
    logic [RX_PAYLOAD_IDX_W-1:0]     calc_win;

    assign out_free = !res_val || res_rdy;
    assign s1_fire  = s1_val && out_free;
    assign pkt_rdy  = !s1_val || out_free;
    assign pkt_fire = pkt_val && pkt_rdy;

    // State is read live when S1 fires and written back on the same edge,
    // so a following packet on the same flow sees it with no bypass path.
    // A cons write landing this cycle is not visible yet (old head used).
    assign s1_state = flow_state[s1_flow_id];

    rx_ack_calc u_calc (
        .state     (s1_state),
        .seq       (s1_seq),
        .len       (s1_len),
        .accept    (calc_accept),
        .ack_next  (calc_ack),
        .tail_next (calc_tail),
        .win       (calc_win)
    );

    // Stage-1 register and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_val      <= 1'b0;
            s1_flow_id  <= '0;
            s1_seq      <= '0;
            s1_len      <= '0;
            res_val     <= 1'b0;
            res_flow_id <= '0;
            res_ack_num <= '0;
            res_accept  <= 1'b0;
            res_wr_ptr  <= '0;
            res_win     <= '0;
        end else begin
            if (pkt_fire) begin
                s1_val     <= 1'b1;
                s1_flow_id <= pkt_flow_id;
                s1_seq     <= pkt_seq_num;
                s1_len     <= pkt_payload_len;
            end else if (s1_fire) begin
                s1_val <= 1'b0;
            end

            if (s1_fire) begin
                res_val     <= 1'b1;
                res_flow_id <= s1_flow_id;
                res_ack_num <= calc_ack;
                res_accept  <= calc_accept;
                res_wr_ptr  <= s1_state.tail_ptr;
                res_win     <= calc_win;
            end else if (res_rdy) begin
                res_val <= 1'b0;
            end
        end
    end

    // Per-flow state. Write order gives priority: init > cons/writeback.
    // Writeback and cons touch disjoint fields, so both apply together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                flow_state[i] <= '0;
            end
        end else begin
            if (s1_fire && calc_accept) begin
                flow_state[s1_flow_id].ack_num  <= calc_ack;
                flow_state[s1_flow_id].tail_ptr <= calc_tail;
            end
            if (cons_val) begin
                flow_state[cons_flow_id].head_ptr <= cons_head_ptr;
            end
            if (init_val) begin
                flow_state[init_flow_id].ack_num  <= init_ack_num;
                flow_state[init_flow_id].tail_ptr <= '0;
                flow_state[init_flow_id].head_ptr <= '0;
            end
        end
    end

`ifdef RX_ACK_DUPCNT_EN
    logic [DUP_CNT_W-1:0] dup_cnt [NUM_FLOWS];
    logic [DUP_CNT_W-1:0] dup_next;

    assign dup_next = dup_cnt_step(dup_cnt[s1_flow_id], calc_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                dup_cnt[i] <= '0;
            end
            res_dup_cnt <= '0;
        end else begin
            if (s1_fire) begin
                dup_cnt[s1_flow_id] <= dup_next;
                res_dup_cnt         <= dup_next;
            end
            if (init_val) begin
                dup_cnt[init_flow_id] <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_ack_flow_tracker.sv
`timescale 1ns/1ps
module tb_rx_ack_flow_tracker;
    import tcp_pkg::*;

    localparam int NF   = 8;
    localparam int FW   = 3;
    localparam int BUF  = 1 << RX_PAYLOAD_PTR_W;
    localparam int MASK = (2 * BUF) - 1;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            init_val;
    logic [FW-1:0]                   init_flow_id;
    logic [ACK_NUM_W-1:0]            init_ack_num;
    logic                            pkt_val;
    logic                            pkt_rdy;
    logic [FW-1:0]                   pkt_flow_id;
    logic [SEQ_NUM_W-1:0]            pkt_seq_num;
    logic [PAYLOAD_ENTRY_LEN_W-1:0]  pkt_payload_len;
    logic                            cons_val;
    logic [FW-1:0]                   cons_flow_id;
    logic [RX_PAYLOAD_PTR_W:0]       cons_head_ptr;
    logic                            res_val;
    logic                            res_rdy;
    logic [FW-1:0]                   res_flow_id;
    logic [ACK_NUM_W-1:0]            res_ack_num;
    logic                            res_accept;
    logic [RX_PAYLOAD_PTR_W:0]       res_wr_ptr;
    logic [RX_PAYLOAD_PTR_W:0]       res_win;
`ifdef RX_ACK_DUPCNT_EN
    logic [DUP_CNT_W-1:0]            res_dup_cnt;
`endif

    rx_ack_flow_tracker #(.NUM_FLOWS(NF)) dut (
        .clk(clk), .rst(rst),
        .init_val(init_val), .init_flow_id(init_flow_id), .init_ack_num(init_ack_num),
        .pkt_val(pkt_val), .pkt_rdy(pkt_rdy), .pkt_flow_id(pkt_flow_id),
        .pkt_seq_num(pkt_seq_num), .pkt_payload_len(pkt_payload_len),
        .cons_val(cons_val), .cons_flow_id(cons_flow_id), .cons_head_ptr(cons_head_ptr),
        .res_val(res_val), .res_rdy(res_rdy), .res_flow_id(res_flow_id),
        .res_ack_num(res_ack_num), .res_accept(res_accept),
        .res_wr_ptr(res_wr_ptr), .res_win(res_win)
`ifdef RX_ACK_DUPCNT_EN
        , .res_dup_cnt(res_dup_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct { int flow; bit [31:0] ack; bit acc; int wr; int win; int dup; } res_t;
    typedef struct { int flow; bit [31:0] seq; int len; } pkt_t;

    bit [31:0] m_ack  [NF];
    int        m_tail [NF];
    int        m_head [NF];
    int        m_dup  [NF];
    bit        m_s1_occ;
    pkt_t      m_s1;
    bit        m_out_occ;
    res_t      m_out;

    res_t got[$];
    pkt_t pend[$];

    bit        nx_rst, nx_res_rdy, nx_init_val, nx_cons_val;
    int        nx_init_flow, nx_cons_flow, nx_cons_head;
    bit [31:0] nx_init_ack;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One packet evaluated against the receive rules.
    function automatic res_t evaluate(input pkt_t p);
        res_t r;
        int used, left;
        used  = (m_tail[p.flow] - m_head[p.flow]) & MASK;
        left  = BUF - used;
        r.flow = p.flow;
        r.acc  = (p.seq == m_ack[p.flow]) && (left >= p.len);
        r.wr   = m_tail[p.flow];
        r.ack  = r.acc ? (p.seq + 32'(p.len)) : m_ack[p.flow];
        r.win  = r.acc ? (left - p.len) : left;
        r.dup  = r.acc ? 0 : ((m_dup[p.flow] < 7) ? m_dup[p.flow] + 1 : 7);
        return r;
    endfunction

    task automatic model_step(input bit exp_rdy);
        bit out_free, fire, take;
        if (rst) begin
            for (int i = 0; i < NF; i++) begin
                m_ack[i] = 0; m_tail[i] = 0; m_head[i] = 0; m_dup[i] = 0;
            end
            m_s1_occ = 0;
            m_out_occ = 0;
            return;
        end
        out_free = !m_out_occ || res_rdy;
        fire     = m_s1_occ && out_free;
        take     = pkt_val && exp_rdy;
        if (fire) begin
            m_out     = evaluate(m_s1);
            m_out_occ = 1;
            if (m_out.acc) begin
                m_ack[m_out.flow]  = m_out.ack;
                m_tail[m_out.flow] = (m_tail[m_out.flow] + m_s1.len) & MASK;
            end
            m_dup[m_out.flow] = m_out.dup;
        end else if (m_out_occ && res_rdy) begin
            m_out_occ = 0;
        end
        if (cons_val) m_head[cons_flow_id] = int'(cons_head_ptr);
        if (init_val) begin
            m_ack[init_flow_id]  = init_ack_num;
            m_tail[init_flow_id] = 0;
            m_head[init_flow_id] = 0;
            m_dup[init_flow_id]  = 0;
        end
        if (take) begin
            m_s1     = pend.pop_front();
            m_s1_occ = 1;
        end else if (fire) begin
            m_s1_occ = 0;
        end
    endtask

    // Drive at the falling edge, compare, then advance the model across
    // the coming rising edge.
    task automatic cycle();
        bit exp_rdy;
        @(negedge clk);
        rst           = nx_rst;
        res_rdy       = nx_res_rdy;
        init_val      = nx_init_val;
        init_flow_id  = FW'(nx_init_flow);
        init_ack_num  = nx_init_ack;
        cons_val      = nx_cons_val;
        cons_flow_id  = FW'(nx_cons_flow);
        cons_head_ptr = RX_PAYLOAD_IDX_W'(nx_cons_head);
        pkt_val       = (pend.size() > 0);
        if (pkt_val) begin
            pkt_flow_id     = FW'(pend[0].flow);
            pkt_seq_num     = pend[0].seq;
            pkt_payload_len = PAYLOAD_ENTRY_LEN_W'(pend[0].len);
        end
        #1;
        exp_rdy = !m_s1_occ || !m_out_occ || res_rdy;
        if (!rst) begin
            chk("pkt_rdy", pkt_rdy, exp_rdy);
            chk("res_val", res_val, m_out_occ);
            if (m_out_occ) begin
                chk("res_flow_id", res_flow_id, m_out.flow);
                chk("res_ack_num", res_ack_num, m_out.ack);
                chk("res_accept",  res_accept,  m_out.acc);
                chk("res_wr_ptr",  res_wr_ptr,  m_out.wr);
                chk("res_win",     res_win,     m_out.win);
`ifdef RX_ACK_DUPCNT_EN
                chk("res_dup_cnt", res_dup_cnt, m_out.dup);
`endif
                if (res_rdy) got.push_back(m_out);
            end
        end
        model_step(exp_rdy);
        nx_init_val = 0;
        nx_cons_val = 0;
    endtask

    task automatic send(input int f, input bit [31:0] seq, input int len);
        pkt_t p;
        p.flow = f; p.seq = seq; p.len = len;
        pend.push_back(p);
    endtask

    task automatic do_init(input int f, input bit [31:0] ack);
        nx_init_val = 1; nx_init_flow = f; nx_init_ack = ack;
        cycle();
    endtask

    task automatic drain();
        int n = 0;
        nx_res_rdy = 1;
        while ((pend.size() > 0 || m_s1_occ || m_out_occ) && n < 300) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (n < 300), 1);
    endtask

    // Pins the model's popped results to hand-computed values.
    task automatic expect_res(input string name, input int f, input bit [31:0] ack,
                              input bit acc, input int wr, input int win, input int dup);
        res_t r;
        if (got.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: actual=no result required=one result", name);
        end else begin
            r = got.pop_front();
            chk({name, "_flow"}, r.flow, f);
            chk({name, "_ack"},  r.ack,  ack);
            chk({name, "_acc"},  r.acc,  acc);
            chk({name, "_wr"},   r.wr,   wr);
            chk({name, "_win"},  r.win,  win);
`ifdef RX_ACK_DUPCNT_EN
            chk({name, "_dup"},  r.dup,  dup);
`else
            if (dup < 0) $display("unreachable");
`endif
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_res_val"}, res_val, 0);
        chk({name, "_res_ack"}, res_ack_num, 0);
        chk({name, "_res_wr"},  res_wr_ptr, 0);
        chk({name, "_res_win"}, res_win, 0);
        chk({name, "_res_acc"}, res_accept, 0);
        chk({name, "_pkt_rdy"}, pkt_rdy, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, used;
        rst = 1; res_rdy = 1; init_val = 0; init_flow_id = '0; init_ack_num = '0;
        pkt_val = 0; pkt_flow_id = '0; pkt_seq_num = '0; pkt_payload_len = '0;
        cons_val = 0; cons_flow_id = '0; cons_head_ptr = '0;
        nx_rst = 1; nx_res_rdy = 1;

        repeat (3) cycle();
        nx_rst = 0;
        cycle();
        check_idle_outputs("reset");

        // Basic accept, duplicate acks and saturation.
        do_init(3, 1000);
        got.delete();
        send(3, 1000, 64);
        drain();
        expect_res("first_pkt", 3, 1064, 1, 0, BUF - 64, 0);
        for (int k = 1; k <= 8; k++) begin
            send(3, 900, 16);
            drain();
            expect_res("dup_ack", 3, 1064, 0, 64, BUF - 64, (k < 7) ? k : 7);
        end

        // Window exhaustion, then head advance reopens it.
        send(3, 1064, 950);
        drain();
        expect_res("fill", 3, 2014, 1, 64, 10, 0);
        send(3, 2014, 11);
        drain();
        expect_res("win_reject", 3, 2014, 0, 1014, 10, 1);
        nx_cons_val = 1; nx_cons_flow = 3; nx_cons_head = 100;
        cycle();
        send(3, 2014, 11);
        drain();
        expect_res("win_retry", 3, 2025, 1, 1014, 99, 0);

        // Sequence wrap and zero-length packet.
        do_init(5, 32'hFFFF_FFF0);
        send(5, 32'hFFFF_FFF0, 32);
        drain();
        expect_res("seq_wrap", 5, 32'h0000_0010, 1, 0, BUF - 32, 0);
        send(5, 32'h0000_0010, 0);
        drain();
        expect_res("zero_len", 5, 32'h0000_0010, 1, 32, BUF - 32, 0);

        // Back-to-back same flow under output stall.
        do_init(1, 0);
        got.delete();
        nx_res_rdy = 0;
        send(1, 0, 10); send(1, 10, 20); send(1, 30, 5);
        repeat (5) cycle();
        chk("stall_pkt_rdy", pkt_rdy, 0);
        chk("stall_res_val", res_val, 1);
        drain();
        expect_res("b2b_0", 1, 10, 1, 0,  BUF - 10, 0);
        expect_res("b2b_1", 1, 30, 1, 10, BUF - 30, 0);
        expect_res("b2b_2", 1, 35, 1, 30, BUF - 35, 0);

        // Reset while a packet sits in stage 1.
        send(3, 2025, 4);
        cycle();
        nx_rst = 1;
        cycle();
        nx_rst = 0;
        cycle();
        check_idle_outputs("mid_reset");
        got.delete();
        send(3, 0, 5);
        drain();
        expect_res("post_reset", 3, 5, 1, 0, BUF - 5, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if (pend.size() < 2 && $urandom_range(0, 2) != 0) begin
                f = $urandom_range(0, NF - 1);
                send(f, ($urandom_range(0, 9) < 7) ? m_ack[f] : 32'($urandom),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300));
            end
            if ($urandom_range(0, 3) == 0) begin
                f = $urandom_range(0, NF - 1);
                used = (m_tail[f] - m_head[f]) & MASK;
                nx_cons_val  = 1;
                nx_cons_flow = f;
                nx_cons_head = (m_head[f] + $urandom_range(0, used)) & MASK;
            end
            if ($urandom_range(0, 59) == 0) begin
                nx_init_val  = 1;
                nx_init_flow = $urandom_range(0, NF - 1);
                nx_init_ack  = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0) | 32'($urandom_range(0, 255));
            end
            nx_res_rdy = ($urandom_range(0, 3) != 0);
            cycle();
            got.delete();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
